// File: rtl/note_writer_pkg.sv
// Shared widths, payload field layout and helpers for the multi-channel note writer.
package note_writer_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DUR_W  = 9;

  // Field LSB offsets inside the payload at default widths: {addr, hold, note, dur}.
  localparam int DUR_LSB   = 0;
  localparam int NOTE_LSB  = DUR_LSB + DEF_DUR_W;
  localparam int HOLD_BIT  = NOTE_LSB + DEF_NOTE_W;
  localparam int ADDR_LSB  = HOLD_BIT + 1;
  localparam int PAYLOAD_W = ADDR_LSB + DEF_ADDR_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  hold;
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_DUR_W-1:0]  dur;
  } note_payload_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_note_writer_if.sv
// Completed-note write handshake toward the RAM side.
interface multi_note_writer_if import note_writer_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DUR_W  = DEF_DUR_W
) ();
  localparam int PAYLOAD_W = ADDR_W + 1 + NOTE_W + DUR_W;
  localparam int CH_W      = ch_idx_w(NUM_CH);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [PAYLOAD_W-1:0] wr_payload;
  logic [CH_W-1:0]      wr_ch;

  modport master (output wr_valid, wr_payload, wr_ch, input wr_ready);
  modport slave  (input wr_valid, wr_payload, wr_ch, output wr_ready);
endinterface

// File: rtl/note_writer_ch.sv
// One switch channel: edge detect, active note capture, beat counter, single pending slot.
// MULTI_NOTE_WRITER_SYNC_EN adds a 2-flop synchronizer on the switch input.
module note_writer_ch import note_writer_pkg::*; #(
  parameter int NOTE_W  = DEF_NOTE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DUR_W   = DEF_DUR_W,
  parameter int IS_HOLD = 0,
  localparam int PAYLOAD_W = ADDR_W + 1 + NOTE_W + DUR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 beat,
  input  logic [ADDR_W-1:0]    cur_ram,
  input  logic                 switch,
  input  logic [NOTE_W-1:0]    note,
  input  logic                 clr,
  output logic                 high_pulse,
  output logic                 low_pulse,
  output logic                 pend_vld,
  output logic [PAYLOAD_W-1:0] pend_payload,
  output logic                 drop
);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic HOLD_FLAG = (IS_HOLD != 0);

  logic sw_in;
`ifdef MULTI_NOTE_WRITER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], switch};
  assign sw_in = sync[1];
`else
  assign sw_in = switch;
`endif

  logic              s, s2;
  logic [ADDR_W-1:0] act_addr;
  logic [NOTE_W-1:0] act_note;
  logic [DUR_W-1:0]  dur, dur_nxt;

  assign high_pulse = s & ~s2;
  assign low_pulse  = ~s & s2;
  // A slot being accepted this cycle frees up in time for the new note.
  assign drop       = low_pulse & pend_vld & ~clr;

  always_comb begin
    dur_nxt = dur;
    if (high_pulse)                          dur_nxt = '0;
    else if (beat && s && (dur != DUR_MAX))  dur_nxt = dur + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s            <= 1'b0;
      s2           <= 1'b0;
      act_addr     <= '0;
      act_note     <= '0;
      dur          <= '0;
      pend_vld     <= 1'b0;
      pend_payload <= '0;
    end else begin
      s   <= sw_in;
      s2  <= s;
      dur <= dur_nxt;
      if (high_pulse) begin
        act_addr <= cur_ram;
        act_note <= note;
      end
      if (low_pulse && (!pend_vld || clr)) begin
        pend_vld     <= 1'b1;
        pend_payload <= {act_addr, HOLD_FLAG, act_note, dur_nxt};
      end else if (clr) begin
        pend_vld <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/multi_note_writer.sv
// Multi-channel note writer: per-channel note capture plus round-robin write arbitration.
// Build option MULTI_NOTE_WRITER_SYNC_EN synchronizes each switch bit (2 extra cycles).
module multi_note_writer import note_writer_pkg::*; #(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int NOTE_W  = DEF_NOTE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DUR_W   = DEF_DUR_W,
  parameter int IS_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     beat,
  input  logic [ADDR_W-1:0]        cur_ram,
  input  logic [NUM_CH-1:0]        switch,
  input  logic [NUM_CH*NOTE_W-1:0] note,
  output logic [NUM_CH-1:0]        switch_high_pulse,
  output logic [NUM_CH-1:0]        switch_low_pulse,
  output logic                     overflow,
  input  logic                     ovf_clr,
  multi_note_writer_if.master      wr
);
  localparam int PAYLOAD_W = ADDR_W + 1 + NOTE_W + DUR_W;
  localparam int CH_W      = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0]                pend_vld, drop, clr;
  logic [NUM_CH-1:0][PAYLOAD_W-1:0] pend_payload;
  logic                 out_vld, accept, found;
  logic [CH_W-1:0]      out_ch, ptr, ptr_eff, pick;
  logic [PAYLOAD_W-1:0] out_payload;

  function automatic logic [CH_W-1:0] nxt_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH-1)) ? '0 : c + 1'b1;
  endfunction

  assign accept = out_vld & wr.wr_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign clr[i] = accept && (out_ch == CH_W'(i));
    note_writer_ch #(
      .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .IS_HOLD(IS_HOLD)
    ) u_ch (
      .clk(clk), .reset_n(reset_n), .beat(beat), .cur_ram(cur_ram),
      .switch(switch[i]), .note(note[i*NOTE_W +: NOTE_W]), .clr(clr[i]),
      .high_pulse(switch_high_pulse[i]), .low_pulse(switch_low_pulse[i]),
      .pend_vld(pend_vld[i]), .pend_payload(pend_payload[i]), .drop(drop[i])
    );
  end

  // Round-robin scan; the slot being accepted this cycle is excluded.
  always_comb begin
    int j;
    j       = 0;
    ptr_eff = accept ? nxt_ch(out_ch) : ptr;
    pick    = ptr_eff;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr_eff) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && pend_vld[j] && !clr[j]) begin
        found = 1'b1;
        pick  = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld     <= 1'b0;
      out_ch      <= '0;
      out_payload <= '0;
      ptr         <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) ptr <= nxt_ch(out_ch);
      // Grant stays locked while the offer is stalled.
      if (!out_vld || wr.wr_ready) begin
        out_vld     <= found;
        out_ch      <= found ? pick : '0;
        out_payload <= found ? pend_payload[pick] : '0;
      end
      if (|drop)        overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign wr.wr_valid   = out_vld;
  assign wr.wr_ch      = out_ch;
  assign wr.wr_payload = out_payload;
endmodule

// File: tb/tb_multi_note_writer.sv
// Directed bench for multi_note_writer: vector table of single notes plus arbitration,
// overflow, saturation and reset sequences. Honors MULTI_NOTE_WRITER_SYNC_EN latencies.
`timescale 1ns/1ps
module tb_multi_note_writer;
  import note_writer_pkg::*;

  localparam int NUM_CH = 4, NOTE_W = 6, ADDR_W = 7, DUR_W = 9;
`ifdef MULTI_NOTE_WRITER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int PULSE_LAT = 1 + SYNC_LAT;
  localparam int WR_LAT    = 3 + SYNC_LAT;

  logic clk = 1'b0, reset_n = 1'b0, beat = 1'b0, ovf_clr = 1'b0;
  logic [ADDR_W-1:0]        cur_ram = '0;
  logic [NUM_CH-1:0]        switch = '0;
  logic [NUM_CH*NOTE_W-1:0] note = '0;
  logic [NUM_CH-1:0]        hp, lp;
  logic                     overflow;
  int n_cmp = 0, n_err = 0;

  multi_note_writer_if #(.NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W)) wr_if ();

  multi_note_writer #(.NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .IS_HOLD(0)) dut (
    .clk(clk), .reset_n(reset_n), .beat(beat), .cur_ram(cur_ram), .switch(switch), .note(note),
    .switch_high_pulse(hp), .switch_low_pulse(lp), .overflow(overflow), .ovf_clr(ovf_clr), .wr(wr_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [NOTE_W-1:0] nt;
    int                beats;
    int                dur;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pay(input logic [6:0] a, input logic [5:0] n, input logic [8:0] d);
    note_payload_t p;
    p.addr = a; p.hold = 1'b0; p.note = n; p.dur = d;
    return 32'(p);
  endfunction

  task automatic wait_hi(input int ch, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      tick();
      if (hp[ch]) begin n = k; break; end
    end
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      tick();
      if (wr_if.wr_valid) begin n = k; break; end
    end
  endtask

  // Raise, count beats, then drop the switch (falling edge driven just after a clock edge).
  task automatic play(input int ch, input logic [6:0] a, input logic [5:0] n, input int beats);
    int t;
    cur_ram = a;
    note[ch*NOTE_W +: NOTE_W] = n;
    switch[ch] = 1'b1;
    wait_hi(ch, 10, t);
    chk($sformatf("hi_pulse_lat_ch%0d", ch), 32'(t), 32'(PULSE_LAT));
    tick();
    beat = 1'b1;
    repeat (beats) tick();
    beat = 1'b0;
    switch[ch] = 1'b0;
  endtask

  task automatic fall_wait(input int ch, output int tl, output int tv);
    tl = -1; tv = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (lp[ch] && tl < 0) tl = k;
      if (wr_if.wr_valid) begin tv = k; break; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int tl, tv, t;
    vecs[0] = '{ch: 0, addr: 7'h12, nt: 6'h05, beats: 3, dur: 3};
    vecs[1] = '{ch: 1, addr: 7'h7F, nt: 6'h3F, beats: 0, dur: 0};
    vecs[2] = '{ch: 2, addr: 7'h00, nt: 6'h2A, beats: 7, dur: 7};
    vecs[3] = '{ch: 3, addr: 7'h55, nt: 6'h11, beats: 1, dur: 1};

    wr_if.wr_ready = 1'b1;
    switch = 4'hF;
    repeat (3) tick();
    chk("rst_valid", 32'(wr_if.wr_valid), 0);
    chk("rst_payload", 32'(wr_if.wr_payload), 0);
    chk("rst_ch", 32'(wr_if.wr_ch), 0);
    chk("rst_pulses", 32'({hp, lp}), 0);
    chk("rst_overflow", 32'(overflow), 0);
    switch = '0;
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      play(vecs[i].ch, vecs[i].addr, vecs[i].nt, vecs[i].beats);
      fall_wait(vecs[i].ch, tl, tv);
      chk($sformatf("vec%0d_lo_lat", i), 32'(tl), 32'(PULSE_LAT));
      chk($sformatf("vec%0d_wr_lat", i), 32'(tv), 32'(WR_LAT));
      chk($sformatf("vec%0d_payload", i), 32'(wr_if.wr_payload),
          pay(vecs[i].addr, vecs[i].nt, 9'(vecs[i].dur)));
      chk($sformatf("vec%0d_ch", i), 32'(wr_if.wr_ch), 32'(vecs[i].ch));
      tick();
      chk($sformatf("vec%0d_idle", i), 32'(wr_if.wr_valid), 0);
    end

    // Simultaneous ch1/ch2 fall with pointer at 0, then ch0/ch3 with pointer at 3.
    cur_ram = 7'h40; note[6 +: 6] = 6'h01; note[12 +: 6] = 6'h02;
    switch[2:1] = 2'b11;
    repeat (PULSE_LAT + 2) tick();
    switch[2:1] = 2'b00;
    wait_valid(WR_LAT + 5, t);
    chk("pair1_lat", 32'(t), 32'(WR_LAT));
    chk("pair1_first_ch", 32'(wr_if.wr_ch), 1);
    chk("pair1_first_payload", 32'(wr_if.wr_payload), pay(7'h40, 6'h01, 0));
    tick();
    chk("pair1_second_vld", 32'(wr_if.wr_valid), 1);
    chk("pair1_second_ch", 32'(wr_if.wr_ch), 2);
    chk("pair1_second_payload", 32'(wr_if.wr_payload), pay(7'h40, 6'h02, 0));
    tick();
    chk("pair1_idle", 32'(wr_if.wr_valid), 0);

    cur_ram = 7'h41; note[0 +: 6] = 6'h0A; note[18 +: 6] = 6'h0D;
    switch = 4'b1001;
    repeat (PULSE_LAT + 2) tick();
    switch = 4'b0000;
    wait_valid(WR_LAT + 5, t);
    chk("pair2_first_ch", 32'(wr_if.wr_ch), 3);
    chk("pair2_first_payload", 32'(wr_if.wr_payload), pay(7'h41, 6'h0D, 0));
    tick();
    chk("pair2_second_ch", 32'(wr_if.wr_ch), 0);
    chk("pair2_second_payload", 32'(wr_if.wr_payload), pay(7'h41, 6'h0A, 0));
    tick();
    chk("pair2_idle", 32'(wr_if.wr_valid), 0);

    // Stalled ch0 entry, second ch0 note is dropped and flagged.
    wr_if.wr_ready = 1'b0;
    play(0, 7'h21, 6'h09, 2);
    fall_wait(0, tl, tv);
    chk("ovf_first_lat", 32'(tv), 32'(WR_LAT));
    chk("ovf_first_payload", 32'(wr_if.wr_payload), pay(7'h21, 6'h09, 2));
    chk("ovf_clear_before", 32'(overflow), 0);
    play(0, 7'h30, 6'h0C, 1);
    repeat (PULSE_LAT + 2) tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_payload_held", 32'(wr_if.wr_payload), pay(7'h21, 6'h09, 2));
    chk("ovf_ch_held", 32'(wr_if.wr_ch), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    wr_if.wr_ready = 1'b1;
    tick();
    chk("ovf_dropped_absent", 32'(wr_if.wr_valid), 0);

    // Duration saturation.
    play(1, 7'h0A, 6'h15, 600);
    fall_wait(1, tl, tv);
    chk("sat_lat", 32'(tv), 32'(WR_LAT));
    chk("sat_payload", 32'(wr_if.wr_payload), pay(7'h0A, 6'h15, 9'd511));
    tick();
    chk("sat_idle", 32'(wr_if.wr_valid), 0);

    // Reset while ch3 is pending and held high.
    wr_if.wr_ready = 1'b0;
    play(3, 7'h33, 6'h33, 2);
    fall_wait(3, tl, tv);
    chk("rst3_pending_lat", 32'(tv), 32'(WR_LAT));
    cur_ram = 7'h44; note[18 +: 6] = 6'h22;
    switch[3] = 1'b1;
    repeat (PULSE_LAT + 2) tick();
    reset_n = 1'b0;
    #1;
    chk("rst3_valid_async", 32'(wr_if.wr_valid), 0);
    chk("rst3_payload_async", 32'(wr_if.wr_payload), 0);
    chk("rst3_pulses", 32'({hp, lp}), 0);
    tick();
    reset_n = 1'b1;
    wait_hi(3, 10, t);
    chk("rst3_rehi_lat", 32'(t), 32'(PULSE_LAT));
    tick();
    wr_if.wr_ready = 1'b1;
    switch[3] = 1'b0;
    fall_wait(3, tl, tv);
    chk("rst3_new_lat", 32'(tv), 32'(WR_LAT));
    chk("rst3_new_payload", 32'(wr_if.wr_payload), pay(7'h44, 6'h22, 0));
    chk("rst3_new_ch", 32'(wr_if.wr_ch), 3);
    tick();
    chk("rst3_idle", 32'(wr_if.wr_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
